// File: rtl/piso_if.sv
// piso_if: load handshake and serial output bundle for piso_tx.
// master drives the word, slave is the transmitter.
interface piso_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] pi;
    logic             load_valid;
    logic             load_ready;
    logic             so;
    logic             so_valid;
    logic             frame_done;
    logic             busy;
    modport master (output pi, load_valid, input load_ready, so, so_valid, frame_done, busy);
    modport slave  (input pi, load_valid, output load_ready, so, so_valid, frame_done, busy);
endinterface

// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter, MSB first, with optional even parity bit.
// Optional feature macro: PARITY_EN appends one even-parity bit to every frame.
module piso_tx #(
    parameter int WIDTH      = 4,
    parameter int GAP_CYCLES = 1
) (
    input logic  clk,
    input logic  clear,
    piso_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GLOAD = GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
`ifdef PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, GAP, PAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
`endif
    state_t           state, state_n;
    // only the bits still to be sent are kept; the MSB goes straight to so
    logic [WIDTH-2:0] shreg, shreg_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [GW-1:0]    gcnt, gcnt_n;
    logic             so_n, so_valid_n, frame_done_n, busy_n, accept;
`ifdef PARITY_EN
    logic             par, par_n;
`endif
    assign bus.load_ready = state == IDLE && !clear;
    assign accept         = bus.load_valid && bus.load_ready;
    always_comb begin
        state_n      = state;
        shreg_n      = shreg;
        cnt_n        = cnt;
        gcnt_n       = gcnt;
        so_n         = 1'b0;
        so_valid_n   = 1'b0;
        frame_done_n = 1'b0;
`ifdef PARITY_EN
        par_n        = par;
`endif
        case (state)
            IDLE: if (accept) begin
                state_n    = SHIFT;
                shreg_n    = bus.pi[WIDTH-2:0];
                cnt_n      = CW'(WIDTH);
                so_n       = bus.pi[WIDTH-1];
                so_valid_n = 1'b1;
`ifdef PARITY_EN
                par_n      = ^bus.pi;
`endif
            end
            SHIFT: if (cnt > CW'(1)) begin
                shreg_n    = shreg << 1;
                cnt_n      = cnt - CW'(1);
                so_n       = shreg[WIDTH-2];
                so_valid_n = 1'b1;
`ifndef PARITY_EN
                frame_done_n = cnt == CW'(2);
`endif
            end else begin
                cnt_n  = '0;
                gcnt_n = GLOAD;
`ifdef PARITY_EN
                state_n      = PAR;
                so_n         = par;
                so_valid_n   = 1'b1;
                frame_done_n = 1'b1;
`else
                state_n = GAP_CYCLES > 0 ? GAP : IDLE;
`endif
            end
`ifdef PARITY_EN
            PAR: begin
                state_n = GAP_CYCLES > 0 ? GAP : IDLE;
                gcnt_n  = GLOAD;
            end
`endif
            GAP: begin
                state_n = gcnt == '0 ? IDLE : GAP;
                gcnt_n  = gcnt == '0 ? gcnt : gcnt - GW'(1);
            end
            default: state_n = IDLE;
        endcase
        busy_n = state_n != IDLE;
    end
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state          <= IDLE;
            shreg          <= '0;
            cnt            <= '0;
            gcnt           <= '0;
            bus.so         <= 1'b0;
            bus.so_valid   <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.busy       <= 1'b0;
`ifdef PARITY_EN
            par            <= 1'b0;
`endif
        end else begin
            state          <= state_n;
            shreg          <= shreg_n;
            cnt            <= cnt_n;
            gcnt           <= gcnt_n;
            bus.so         <= so_n;
            bus.so_valid   <= so_valid_n;
            bus.frame_done <= frame_done_n;
            bus.busy       <= busy_n;
`ifdef PARITY_EN
            par            <= par_n;
`endif
        end
    end
endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: directed stimulus with a scoreboard queue of expected serial bits and cycles.
module tb_piso_tx;
    localparam int W = 4;
    localparam int G = 1;
`ifdef PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int PER = W + G + 1 + (PAR ? 1 : 0);

    typedef struct {
        logic so;
        logic fd;
        int   cyc;
    } exp_t;

    logic   clk = 1'b0;
    logic   clear = 1'b1;
    exp_t   q[$];
    exp_t   e;
    int     cyc = 0;
    int     total = 0;
    int     bad = 0;

    piso_if #(.WIDTH(W)) bus ();
    piso_tx #(.WIDTH(W), .GAP_CYCLES(G)) dut (.clk(clk), .clear(clear), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // seq is the hand-written serial order (first bit sent on the left), a the cycle of bit 1
    task automatic push(input logic [W-1:0] seq, input logic p, input int a);
        exp_t x;
        for (int i = 0; i < W; i++) begin
            x.so  = seq[W-1-i];
            x.fd  = !PAR && i == W - 1;
            x.cyc = a + i;
            q.push_back(x);
        end
        if (PAR) begin
            x.so  = p;
            x.fd  = 1'b1;
            x.cyc = a + W;
            q.push_back(x);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] word, input logic [W-1:0] seq, input logic p);
        bus.pi         = word;
        bus.load_valid = 1'b1;
        push(seq, p, cyc + 1);
        tick();
        bus.load_valid = 1'b0;
        bus.pi         = ~word;
    endtask

    always @(negedge clk) begin
        if (!clear) begin
            if (bus.so_valid) begin
                if (q.size() == 0) check("extra_bit", 32'(bus.so_valid), 32'd0);
                else begin
                    e = q.pop_front();
                    check("so", 32'(bus.so), 32'(e.so));
                    check("frame_done", 32'(bus.frame_done), 32'(e.fd));
                    check("bit_cycle", cyc, e.cyc);
                end
            end else begin
                check("idle_so", 32'(bus.so), 32'd0);
                check("idle_frame_done", 32'(bus.frame_done), 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.pi         = '0;
        bus.load_valid = 1'b0;
        repeat (2) tick();
        check("rst_so", 32'(bus.so), 32'd0);
        check("rst_so_valid", 32'(bus.so_valid), 32'd0);
        check("rst_frame_done", 32'(bus.frame_done), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_load_ready", 32'(bus.load_ready), 32'd0);
        clear = 1'b0;
        #1;
        check("release_load_ready", 32'(bus.load_ready), 32'd1);
        tick();
        // single word 1011, even parity 1
        send(4'b1011, 4'b1011, 1'b1);
        check("shift_busy", 32'(bus.busy), 32'd1);
        check("shift_load_ready", 32'(bus.load_ready), 32'd0);
        repeat (PER) tick();
        // load_valid held: A then 5 back to back, one frame period apart
        bus.pi         = 4'hA;
        bus.load_valid = 1'b1;
        push(4'b1010, 1'b0, cyc + 1);
        tick();
        bus.pi = 4'h5;
        push(4'b0101, 1'b0, cyc + PER);
        repeat (PER) tick();
        bus.load_valid = 1'b0;
        repeat (PER) tick();
        // load attempt during SHIFT must be ignored
        send(4'b1001, 4'b1001, 1'b0);
        bus.pi         = 4'hF;
        bus.load_valid = 1'b1;
        repeat (2) tick();
        check("busy_load_ready", 32'(bus.load_ready), 32'd0);
        check("busy_busy", 32'(bus.busy), 32'd1);
        bus.load_valid = 1'b0;
        repeat (PER) tick();
        // abort 1100 during its second bit
        send(4'b1100, 4'b1100, 1'b0);
        tick();
        clear = 1'b1;
        q.delete();
        #1;
        check("abort_so", 32'(bus.so), 32'd0);
        check("abort_so_valid", 32'(bus.so_valid), 32'd0);
        check("abort_frame_done", 32'(bus.frame_done), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_load_ready", 32'(bus.load_ready), 32'd0);
        tick();
        clear = 1'b0;
        #1;
        check("abort_release_ready", 32'(bus.load_ready), 32'd1);
        tick();
        send(4'b0011, 4'b0011, 1'b0);
        repeat (PER) tick();
        // parity vectors: 0111 -> 1, 0110 -> 0
        send(4'b0111, 4'b0111, 1'b1);
        repeat (PER) tick();
        send(4'b0110, 4'b0110, 1'b0);
        repeat (PER + 2) tick();
        check("queue_empty", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
